key_debouncer: RTL and testbench
================================

// Module: key_debouncer
// PURPOSE
//  Input conditioner sitting between the raw DE2 push-buttons (KEY, active-low) and the
//  Nios II SoC button PIO. It gives the PIO glitch-free key levels and gives fabric logic
//  one-cycle press/release pulses plus a sticky press-capture register with a clear handshake.
// PARAMETERS
//  N_KEYS        4           number of independent keys
//  DB_CYCLES     500_000     consecutive stable cycles needed to accept a level (10 ms at 50 MHz)
//  REPEAT_DELAY  25_000_000  hold cycles before the first auto-repeat (KEY_REPEAT_EN only)
//  REPEAT_RATE   5_000_000   cycles between repeats after the first one (KEY_REPEAT_EN only)
// PORTS
//  clk_clk        in   1       system clock, 50 MHz (CLOCK_50)
//  reset_reset_n  in   1       asynchronous active-low reset
//  key_n_in       in   N_KEYS  raw asynchronous keys, 0 = pressed
//  key_n_clean    out  N_KEYS  debounced level, 0 = pressed (drives the SoC button PIO)
//  press_pulse    out  N_KEYS  one-cycle pulse when key_n_clean falls
//  release_pulse  out  N_KEYS  one-cycle pulse when key_n_clean rises
//  capture        out  N_KEYS  sticky bit, set by press (and repeat); 1 until cleared
//  capture_clr    in   N_KEYS  per-bit clear request for capture, sampled every cycle
//  repeat_pulse   out  N_KEYS  one-cycle auto-repeat pulse (constant 0 without KEY_REPEAT_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): key_n_clean='1, all pulses 0, capture 0,
//    sync flops '1, counters 0, repeat FSM in RPT_IDLE. Outputs are registered; no combinational paths.
//  - Per key: 2-flop synchronizer (sync_q). Counter cnt, width $clog2(DB_CYCLES+1).
//    If sync_q==clean, cnt<=0. Otherwise cnt<=cnt+1. When cnt==DB_CYCLES-1 and there is
//    still a mismatch, clean<=sync_q and cnt<=0.
//  - Latency: a stable raw change appears on key_n_clean exactly 2+DB_CYCLES cycles after the
//    first clock edge that samples it. Any bounce shorter than DB_CYCLES restarts the count;
//    it never produces a pulse.
//  - press_pulse / release_pulse are asserted in the same cycle that key_n_clean changes,
//    for exactly 1 cycle.
//  - capture[i]: set on press_pulse[i] (or repeat_pulse[i]). Cleared the cycle after
//    capture_clr[i]=1. If set and clear occur in the same cycle, set wins, so no press is lost.
//    Clearing an already-clear bit has no effect.
//  - Keys are fully independent. Simultaneous changes on several keys give simultaneous pulses.
//  - Reset asserted mid-count discards the partial count. A key held through reset release is
//    reported as a press 2+DB_CYCLES cycles after release.
//  - Counter never wraps: it is cleared at DB_CYCLES-1 or on a match.
// CONFIGURATION
//  Macro KEY_REPEAT_EN.
//  - Defined: per-key FSM.
//    RPT_IDLE  --press_pulse--> RPT_DELAY (timer=0)
//    RPT_DELAY --timer==REPEAT_DELAY-1--> RPT_RUN, emits repeat_pulse, timer=0
//    RPT_RUN   --timer==REPEAT_RATE-1--> emits repeat_pulse, timer=0
//    release_pulse in any state returns to RPT_IDLE with no pulse.
//    Timer width is $clog2(max(REPEAT_DELAY,REPEAT_RATE)).
//  - Undefined: no FSM or timers are synthesized. repeat_pulse is tied to '0; all other
//    behaviour is identical.
// STRUCTURE
//  - Package key_debounce_pkg: default constants (DB_CYCLES_DEF, REPEAT_DELAY_DEF,
//    REPEAT_RATE_DEF) and typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_RUN} repeat_state_t.
//  - Sub-module debounce_cell: one key (sync, counter, clean, pulses, optional repeat FSM).
//    It is instantiated N_KEYS times in a generate loop. The capture register stays in
//    key_debouncer.
// TESTING (bench overrides DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5, N_KEYS=4)
//  1. Reset with key_n_in=4'hF -> key_n_clean=4'hF; press/release/repeat=0; capture=0.
//  2. key_n_in[1]=0 held 30 cycles -> key_n_clean[1] falls exactly 10 cycles after the sampling
//     edge; press_pulse[1] high 1 cycle; capture=4'b0010. Release -> release_pulse[1] 10 cycles later.
//  3. key_n_in[2] toggled every 3 cycles for 40 cycles, then held 1 -> key_n_clean stays 4'hF;
//     no pulse; capture unchanged.
//  4. capture[1]=1 and capture_clr[1]=1 in the same cycle as a new press_pulse[1] -> capture[1]
//     stays 1. Next cycle, capture_clr[1]=1 alone -> capture[1]=0.
//  5. key_n_in[0]=0; reset pulsed at count 5 of 8 -> no press_pulse. After reset release,
//     press_pulse[0] arrives exactly 10 cycles later.
//  6. KEY_REPEAT_EN defined, key 3 held 45 cycles after press_pulse -> repeat_pulse[3] at
//     press+20, +25, +30, +35, +40; none after release. Macro undefined -> repeat_pulse always 0.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Shared constants and repeat-FSM state type for the key debouncer.
package key_debounce_pkg;

  localparam int unsigned DB_CYCLES_DEF    = 500_000;
  localparam int unsigned REPEAT_DELAY_DEF = 25_000_000;
  localparam int unsigned REPEAT_RATE_DEF  = 5_000_000;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RUN   = 2'd2
  } repeat_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One key: 2-flop synchronizer, stability counter, clean level, edge pulses and,
// with KEY_REPEAT_EN defined, the auto-repeat FSM.
module debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = DB_CYCLES_DEF
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_raw,
  output logic key_n_clean,
  output logic press_pulse,
  output logic release_pulse
`ifdef KEY_REPEAT_EN
  ,
  output logic repeat_pulse
`endif
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          out_q, out_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // The accepted level passes through one output register; the pulses are
  // registered on the same edge so level and pulse change together.
  always_comb begin
    sync_d  = {sync_q[0], key_n_raw};
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync_q[1] == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      clean_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    out_d   = clean_q;
    press_d = out_q & ~clean_q;
    rel_d   = ~out_q & clean_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      clean_q <= 1'b1;
      out_q   <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_n_clean   = out_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  repeat_state_t rpt_state_q, rpt_state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rpt_q, rpt_d;

  // Driven from the pre-register press/release terms so the FSM is aligned
  // with the cycle in which press_pulse becomes visible.
  always_comb begin
    rpt_state_d = rpt_state_q;
    timer_d     = timer_q;
    rpt_d       = 1'b0;
    if (rel_d) begin
      rpt_state_d = RPT_IDLE;
      timer_d     = '0;
    end else begin
      case (rpt_state_q)
        RPT_IDLE: begin
          if (press_d) begin
            rpt_state_d = RPT_DELAY;
            timer_d     = '0;
          end
        end
        RPT_DELAY: begin
          if (timer_q == TW'(REPEAT_DELAY - 1)) begin
            rpt_state_d = RPT_RUN;
            rpt_d       = 1'b1;
            timer_d     = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        RPT_RUN: begin
          if (timer_q == TW'(REPEAT_RATE - 1)) begin
            rpt_d   = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          rpt_state_d = RPT_IDLE;
          timer_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_state_q <= RPT_IDLE;
      timer_q     <= '0;
      rpt_q       <= 1'b0;
    end else begin
      rpt_state_q <= rpt_state_d;
      timer_q     <= timer_d;
      rpt_q       <= rpt_d;
    end
  end

  assign repeat_pulse = rpt_q;
`endif

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low push-buttons and keeps a sticky press-capture register.
// Define KEY_REPEAT_EN to build the per-key auto-repeat FSM.
module key_debouncer
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned DB_CYCLES    = DB_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_n_in,
  output logic [N_KEYS-1:0] key_n_clean,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] capture,
  input  logic [N_KEYS-1:0] capture_clr,
  output logic [N_KEYS-1:0] repeat_pulse
);

  logic [N_KEYS-1:0] capture_q, capture_d;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_cell #(
      .DB_CYCLES    (DB_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_cell (
      .clk           (clk_clk),
      .rst_n         (reset_reset_n),
      .key_n_raw     (key_n_in[i]),
      .key_n_clean   (key_n_clean[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
`ifdef KEY_REPEAT_EN
      ,
      .repeat_pulse  (repeat_pulse[i])
`endif
    );
  end

`ifndef KEY_REPEAT_EN
  // Repeat timing parameters still participate so overrides stay legal; result is constant 0.
  localparam logic RPT_TIE = 1'b0 && (REPEAT_DELAY != 0) && (REPEAT_RATE != 0);
  assign repeat_pulse = {N_KEYS{RPT_TIE}};
`endif

  // Set has priority over clear so a press coinciding with a clear is kept.
  always_comb begin
    capture_d = (capture_q & ~capture_clr) | press_pulse | repeat_pulse;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      capture_q <= '0;
    end else begin
      capture_q <= capture_d;
    end
  end

  assign capture = capture_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed self-checking bench for key_debouncer (DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5).
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n_in = 4'hF;
  logic [3:0] capture_clr = 4'h0;
  logic [3:0] key_n_clean, press_pulse, release_pulse, capture, repeat_pulse;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned rpt_glob = 0;

  always #5 clk = ~clk;

  key_debouncer #(
    .N_KEYS       (4),
    .DB_CYCLES    (8),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .key_n_in      (key_n_in),
    .key_n_clean   (key_n_clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .capture       (capture),
    .capture_clr   (capture_clr),
    .repeat_pulse  (repeat_pulse)
  );

  always @(negedge clk) if (repeat_pulse !== 4'h0) rpt_glob++;

  // Each tick leaves the bench 1 time unit after a rising edge.
  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_n_in = 4'hF; capture_clr = 4'h0;
    tick(3);
    n_total++; if (key_n_clean !== 4'hF) $display("FAIL reset_clean: got %h want %h", key_n_clean, 4'hF); else n_pass++;
    n_total++; if (press_pulse !== 4'h0) $display("FAIL reset_press: got %h want %h", press_pulse, 4'h0); else n_pass++;
    n_total++; if (release_pulse !== 4'h0) $display("FAIL reset_release: got %h want %h", release_pulse, 4'h0); else n_pass++;
    n_total++; if (capture !== 4'h0) $display("FAIL reset_capture: got %h want %h", capture, 4'h0); else n_pass++;
    n_total++; if (repeat_pulse !== 4'h0) $display("FAIL reset_repeat: got %h want %h", repeat_pulse, 4'h0); else n_pass++;
    rst_n = 1'b1;
    tick(12);
    n_total++; if (key_n_clean !== 4'hF) $display("FAIL post_reset_clean: got %h want %h", key_n_clean, 4'hF); else n_pass++;
  endtask

  task automatic test_press_release();
    key_n_in[1] = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick(1);
      if (t == 10) begin
        n_total++; if (key_n_clean !== 4'hF) $display("FAIL press_early: got %h want %h", key_n_clean, 4'hF); else n_pass++;
      end
      if (t == 11) begin
        n_total++; if (key_n_clean !== 4'hD) $display("FAIL press_clean: got %h want %h", key_n_clean, 4'hD); else n_pass++;
        n_total++; if (press_pulse !== 4'b0010) $display("FAIL press_pulse: got %h want %h", press_pulse, 4'b0010); else n_pass++;
      end
      if (t == 12) begin
        n_total++; if (press_pulse !== 4'h0) $display("FAIL press_width: got %h want %h", press_pulse, 4'h0); else n_pass++;
        n_total++; if (capture !== 4'b0010) $display("FAIL press_capture: got %h want %h", capture, 4'b0010); else n_pass++;
      end
    end
    key_n_in[1] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      if (t == 10) begin
        n_total++; if (key_n_clean !== 4'hD) $display("FAIL release_early: got %h want %h", key_n_clean, 4'hD); else n_pass++;
      end
      if (t == 11) begin
        n_total++; if (release_pulse !== 4'b0010) $display("FAIL release_pulse: got %h want %h", release_pulse, 4'b0010); else n_pass++;
        n_total++; if (key_n_clean !== 4'hF) $display("FAIL release_clean: got %h want %h", key_n_clean, 4'hF); else n_pass++;
      end
      if (t == 12) begin
        n_total++; if (release_pulse !== 4'h0) $display("FAIL release_width: got %h want %h", release_pulse, 4'h0); else n_pass++;
      end
    end
    capture_clr = 4'b0010;
    tick(1);
    capture_clr = 4'h0;
    n_total++; if (capture !== 4'h0) $display("FAIL capture_clear: got %h want %h", capture, 4'h0); else n_pass++;
  endtask

  task automatic test_bounce();
    int unsigned bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) key_n_in[2] = ~key_n_in[2];
      tick(1);
      if (key_n_clean !== 4'hF || press_pulse !== 4'h0 || release_pulse !== 4'h0) bad++;
    end
    key_n_in[2] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (key_n_clean !== 4'hF || press_pulse !== 4'h0 || release_pulse !== 4'h0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL bounce_glitches: got %0d want 0", bad); else n_pass++;
    n_total++; if (capture !== 4'h0) $display("FAIL bounce_capture: got %h want %h", capture, 4'h0); else n_pass++;
  endtask

  task automatic test_capture_race();
    key_n_in[1] = 1'b0;
    tick(11);
    n_total++; if (press_pulse !== 4'b0010) $display("FAIL race_setup_press: got %h want %h", press_pulse, 4'b0010); else n_pass++;
    key_n_in[1] = 1'b1;
    tick(12);
    n_total++; if (capture !== 4'b0010) $display("FAIL race_setup_capture: got %h want %h", capture, 4'b0010); else n_pass++;
    key_n_in[1] = 1'b0;
    tick(11);
    n_total++; if (press_pulse !== 4'b0010) $display("FAIL race_press: got %h want %h", press_pulse, 4'b0010); else n_pass++;
    capture_clr[1] = 1'b1;
    tick(1);
    n_total++; if (capture !== 4'b0010) $display("FAIL race_set_wins: got %h want %h", capture, 4'b0010); else n_pass++;
    tick(1);
    n_total++; if (capture !== 4'h0) $display("FAIL race_clear_alone: got %h want %h", capture, 4'h0); else n_pass++;
    capture_clr = 4'h0;
    key_n_in[1] = 1'b1;
    tick(12);
  endtask

  task automatic test_reset_midcount();
    int unsigned early = 0;
    key_n_in[0] = 1'b0;
    tick(7);
    rst_n = 1'b0;
    tick(2);
    n_total++; if (key_n_clean !== 4'hF) $display("FAIL midreset_clean: got %h want %h", key_n_clean, 4'hF); else n_pass++;
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      if (t <= 10 && press_pulse !== 4'h0) early++;
      if (t == 11) begin
        n_total++; if (press_pulse !== 4'b0001) $display("FAIL midreset_press: got %h want %h", press_pulse, 4'b0001); else n_pass++;
        n_total++; if (key_n_clean !== 4'hE) $display("FAIL midreset_clean_after: got %h want %h", key_n_clean, 4'hE); else n_pass++;
      end
    end
    n_total++; if (early !== 0) $display("FAIL midreset_early_pulse: got %0d want 0", early); else n_pass++;
    key_n_in[0] = 1'b1;
    tick(12);
  endtask

  task automatic test_multi();
    capture_clr = 4'hF;
    tick(1);
    capture_clr = 4'h0;
    key_n_in = 4'b1010;
    tick(10);
    n_total++; if (press_pulse !== 4'h0) $display("FAIL multi_early: got %h want %h", press_pulse, 4'h0); else n_pass++;
    tick(1);
    n_total++; if (press_pulse !== 4'b0101) $display("FAIL multi_press: got %h want %h", press_pulse, 4'b0101); else n_pass++;
    n_total++; if (key_n_clean !== 4'b1010) $display("FAIL multi_clean: got %h want %h", key_n_clean, 4'b1010); else n_pass++;
    key_n_in = 4'hF;
    tick(11);
    n_total++; if (release_pulse !== 4'b0101) $display("FAIL multi_release: got %h want %h", release_pulse, 4'b0101); else n_pass++;
    n_total++; if (capture !== 4'b0101) $display("FAIL multi_capture: got %h want %h", capture, 4'b0101); else n_pass++;
    capture_clr = 4'hF;
    tick(1);
    capture_clr = 4'h0;
    tick(2);
  endtask

  task automatic test_repeat();
`ifdef KEY_REPEAT_EN
    int unsigned rpt_err = 0;
    logic exp_rpt;
    key_n_in[3] = 1'b0;
    tick(11);
    n_total++; if (press_pulse !== 4'b1000) $display("FAIL rpt_press: got %h want %h", press_pulse, 4'b1000); else n_pass++;
    for (int c = 1; c <= 60; c++) begin
      tick(1);
      exp_rpt = (c == 20 || c == 25 || c == 30 || c == 35 || c == 40);
      if (repeat_pulse[3] !== exp_rpt || repeat_pulse[2:0] !== 3'b000) rpt_err++;
      if (c == 20) begin
        n_total++; if (repeat_pulse !== 4'b1000) $display("FAIL rpt_first: got %h want %h", repeat_pulse, 4'b1000); else n_pass++;
      end
      if (c == 45) begin
        n_total++; if (release_pulse !== 4'b1000) $display("FAIL rpt_release: got %h want %h", release_pulse, 4'b1000); else n_pass++;
      end
      if (c == 34) key_n_in[3] = 1'b1;
    end
    n_total++; if (rpt_err !== 0) $display("FAIL rpt_schedule: got %0d wrong cycles want 0", rpt_err); else n_pass++;
    n_total++; if (capture !== 4'b1000) $display("FAIL rpt_capture: got %h want %h", capture, 4'b1000); else n_pass++;
`else
    key_n_in[3] = 1'b0;
    tick(11);
    n_total++; if (press_pulse !== 4'b1000) $display("FAIL norpt_press: got %h want %h", press_pulse, 4'b1000); else n_pass++;
    tick(50);
    key_n_in[3] = 1'b1;
    tick(12);
    n_total++; if (rpt_glob !== 0) $display("FAIL norpt_repeat: got %0d pulse cycles want 0", rpt_glob); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_capture_race();
    test_reset_midcount();
    test_multi();
    test_repeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
